mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of addresses and data words.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 mem_read_i  in  1  load request from MEM stage.
REQ-006 mem_write_i  in  1  store request from MEM stage.
REQ-007 size_i  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-008 unsigned_i  in  1  1 = zero-extend loads (LBU/LHU), 0 = sign-extend.
REQ-009 address_i  in  DATA_WIDTH  byte address from ALU.
REQ-010 store_data_i  in  DATA_WIDTH  rt value; sub-word data in low bits.
REQ-011 dm_data_i  in  DATA_WIDTH  combinational read word from data memory.
REQ-012 dm_address_o  out  DATA_WIDTH  address to data memory.
REQ-013 dm_write_data_o  out  DATA_WIDTH  full word to write.
REQ-014 dm_mem_write_o / dm_mem_read_o  out  1 each  memory strobes.
REQ-015 load_data_o  out  DATA_WIDTH  extended load result to WB.
REQ-016 stall_o  out  1  freeze PC and IF/ID/EX/MEM registers this cycle.
REQ-017 misaligned_o  out  1  address exception flag.

Function
REQ-018 Memory is word-only; byte lanes SHALL be little-endian (offset 0 = bits 7:0).
REQ-019 dm_address_o SHALL equal address_i with bits 1:0 forced to 0.
REQ-020 Loads SHALL complete in the request cycle with no stall: select lane by address_i[1:0] (byte) or address_i[1] (half), then extend per unsigned_i.
REQ-021 load_data_o SHALL be 0 when mem_read_i=0; dm_mem_read_o SHALL follow mem_read_i in IDLE.
REQ-022 FSM states SHALL be IDLE and MERGE_WR only.
REQ-023 Word store in IDLE: dm_mem_write_o=1, dm_write_data_o=store_data_i, same cycle, no stall, stay IDLE.
REQ-024 Sub-word store in IDLE: dm_mem_read_o=1, dm_mem_write_o=0, stall_o=1; at the edge register dm_data_i with the target lane replaced by store_data_i low bits; go to MERGE_WR.
REQ-025 MERGE_WR: dm_mem_write_o=1, dm_write_data_o=merged register, stall_o=0, dm_mem_read_o=0; next state IDLE unconditionally.
REQ-026 Upstream SHALL hold all request inputs stable while stall_o=1; the block relies on this for MERGE_WR addressing.
REQ-027 mem_read_i and mem_write_i both high SHALL be treated as a store only.
REQ-028 Back-to-back sub-word stores SHALL each take two cycles; the second starts its read in the cycle after MERGE_WR.
REQ-029 A load directly after a sub-word store SHALL observe the merged word (write committed at MERGE_WR edge).

Reset
REQ-030 On reset low: state IDLE, merged register 0, stall_o=0, dm_mem_write_o=0, misaligned_o=0, independent of clk.
REQ-031 Reset asserted in MERGE_WR SHALL abort with no memory write; memory contents unchanged.

Configuration
REQ-032 Macro MISALIGN_TRAP_EN: when defined, half access with address_i[0]=1 or word access with address_i[1:0]!=0 SHALL raise misaligned_o combinationally, suppress dm_mem_write_o, force load_data_o=0, no stall.
REQ-033 When undefined, misaligned_o SHALL be tied 0 and low address bits ignored per REQ-019/020 (half uses address_i[1] only).

Structure
REQ-034 Shared package SHALL hold size encodings (SIZE_BYTE/HALF/WORD) and the FSM state typedef.
REQ-035 One sub-module, load_extend (combinational lane select + sign/zero extend), is natural; merge logic stays inline.

Verification
REQ-036 Word at 0x10010000 = 0x8899AABB; LB addr 0x10010001 -> load_data_o 0xFFFFFFAA; LBU -> 0x000000AA; LH addr 0x10010002 -> 0xFFFF8899.
REQ-037 SB 0x000000CC at 0x10010002 over 0x8899AABB -> cycle 1 stall_o=1, read; cycle 2 write 0x88CCAABB; stall_o=0.
REQ-038 SW 0x12345678 at 0x10010004 -> single-cycle write, stall_o never 1; subsequent LW returns 0x12345678.
REQ-039 Reset pulsed low during MERGE_WR of SH -> no write; word unchanged; state IDLE, stall_o=0.
REQ-040 With MISALIGN_TRAP_EN: SW at 0x10010002 -> misaligned_o=1, dm_mem_write_o=0; without: write to 0x10010000.
REQ-041 Two consecutive SB to offsets 0 and 3 of 0x00000000 -> 4 cycles total, final word 0xDD0000EE for data 0xEE then 0xDD.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the MEM-stage data memory access unit:
//   - access size encodings carried on size_i
//   - FSM state type for the sub-word store read-modify-write sequence
//   - helper that classifies an access as misaligned for its size
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // IDLE serves loads and word stores in one cycle; MERGE_WR is the write
   // half of a sub-word store.
   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_MERGE_WR = 1'b1
   } mau_state_t;

   // A byte is never misaligned; a half needs bit 0 clear; a word (encodings
   // 10 and 11) needs both low bits clear.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
      logic mis;
      case (size)
         SIZE_BYTE: mis = 1'b0;
         SIZE_HALF: mis = addr_lo[0];
         default:   mis = (addr_lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// -----------------------------------------------------------------------------
// mem_access_unit_load_extend
// Combinational load lane select and sign/zero extension (little-endian lanes).
// Ports:
//   i_word     - full word read from data memory
//   i_size     - access size (byte / half / word; 11 behaves as word)
//   i_offset   - byte offset within the word (bit 1 only is used for halves)
//   i_unsigned - 1 = zero-extend, 0 = sign-extend
//   o_data     - extended load result
// -----------------------------------------------------------------------------
module mem_access_unit_load_extend
   import mem_access_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] i_word,
   input  logic [1:0]            i_size,
   input  logic [1:0]            i_offset,
   input  logic                  i_unsigned,
   output logic [DATA_WIDTH-1:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_byte_fill;
   logic        w_half_fill;

   // Offset 0 is bits 7:0; a half lane is picked by offset bit 1 alone.
   assign w_byte = i_word[{i_offset, 3'b000} +: 8];
   assign w_half = i_word[{i_offset[1], 4'b0000} +: 16];

   assign w_byte_fill = i_unsigned ? 1'b0 : w_byte[7];
   assign w_half_fill = i_unsigned ? 1'b0 : w_half[15];

   // Extend the selected lane to full width.
   always_comb begin
      o_data = i_word;
      case (i_size)
         SIZE_BYTE: o_data = {{(DATA_WIDTH-8){w_byte_fill}}, w_byte};
         SIZE_HALF: o_data = {{(DATA_WIDTH-16){w_half_fill}}, w_half};
         default:   o_data = i_word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage interface to a word-only data memory. Loads complete in the
// request cycle. Word stores write in one cycle. Sub-word stores take two
// cycles: read the word (stall asserted), merge the new lane into a
// register at the edge, then write the merged word in MERGE_WR.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   - misaligned half/word accesses raise misaligned_o, suppress
//               the write, force load_data_o to 0 and never stall.
//   undefined - misaligned_o is 0; low address bits are simply ignored.
//
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   mem_read_i        - load request
//   mem_write_i       - store request (wins when both requests are high)
//   size_i            - 00 byte, 01 half, 10/11 word
//   unsigned_i        - zero-extend loads when 1
//   address_i         - byte address
//   store_data_i      - store data, sub-word data in low bits
//   dm_data_i         - combinational read word from data memory
//   dm_address_o      - word-aligned memory address
//   dm_write_data_o   - full word to write
//   dm_mem_write_o    - memory write strobe
//   dm_mem_read_o     - memory read strobe
//   load_data_o       - extended load result
//   stall_o           - freeze upstream pipeline this cycle
//   misaligned_o      - address exception flag
// -----------------------------------------------------------------------------
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_read_i,
   input  logic                  mem_write_i,
   input  logic [1:0]            size_i,
   input  logic                  unsigned_i,
   input  logic [DATA_WIDTH-1:0] address_i,
   input  logic [DATA_WIDTH-1:0] store_data_i,
   input  logic [DATA_WIDTH-1:0] dm_data_i,
   output logic [DATA_WIDTH-1:0] dm_address_o,
   output logic [DATA_WIDTH-1:0] dm_write_data_o,
   output logic                  dm_mem_write_o,
   output logic                  dm_mem_read_o,
   output logic [DATA_WIDTH-1:0] load_data_o,
   output logic                  stall_o,
   output logic                  misaligned_o
);

   mau_state_t            r_state;
   mau_state_t            w_state_next;
   logic [DATA_WIDTH-1:0] r_merge;
   logic [DATA_WIDTH-1:0] w_merge_next;
   logic [DATA_WIDTH-1:0] w_merged_word;
   logic [DATA_WIDTH-1:0] w_ext_data;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [DATA_WIDTH-1:0] w_load;
   logic                  w_rd;
   logic                  w_wr;
   logic                  w_stall;
   logic                  w_mis_out;
   logic                  w_is_word;
   logic                  w_misaligned;

   // Size 11 is handled exactly like a word.
   assign w_is_word = size_i[1];

`ifdef MISALIGN_TRAP_EN
   assign w_misaligned = is_misaligned(size_i, address_i[1:0]);
`else
   assign w_misaligned = 1'b0;
`endif

   assign dm_address_o = {address_i[DATA_WIDTH-1:2], 2'b00};

   mem_access_unit_load_extend #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_load_extend (
      .i_word     (dm_data_i),
      .i_size     (size_i),
      .i_offset   (address_i[1:0]),
      .i_unsigned (unsigned_i),
      .o_data     (w_ext_data)
   );

   // Memory word with the target store lane replaced by the new data.
   always_comb begin
      w_merged_word = dm_data_i;
      case (size_i)
         SIZE_BYTE: w_merged_word[{address_i[1:0], 3'b000} +: 8]   = store_data_i[7:0];
         SIZE_HALF: w_merged_word[{address_i[1], 4'b0000} +: 16]   = store_data_i[15:0];
         default:   w_merged_word = store_data_i;
      endcase
   end

   // Next-state and strobe decode. Outputs are gated by reset so that a
   // request held during reset cannot stall or write.
   always_comb begin
      w_state_next = r_state;
      w_merge_next = r_merge;
      w_rd         = 1'b0;
      w_wr         = 1'b0;
      w_wdata      = store_data_i;
      w_stall      = 1'b0;
      w_load       = {DATA_WIDTH{1'b0}};
      w_mis_out    = 1'b0;
      if (!reset) begin
         w_state_next = ST_IDLE;
      end else begin
         w_mis_out = w_misaligned & (mem_read_i | mem_write_i);
         case (r_state)
            ST_IDLE: begin
               if (mem_write_i) begin
                  // A simultaneous read request is ignored: store only.
                  if (w_misaligned) begin
                     w_wr = 1'b0;
                  end else if (w_is_word) begin
                     w_wr = 1'b1;
                  end else begin
                     w_rd         = 1'b1;
                     w_stall      = 1'b1;
                     w_merge_next = w_merged_word;
                     w_state_next = ST_MERGE_WR;
                  end
               end else if (mem_read_i) begin
                  w_rd = 1'b1;
                  if (w_misaligned) begin
                     w_load = {DATA_WIDTH{1'b0}};
                  end else begin
                     w_load = w_ext_data;
                  end
               end else begin
                  w_rd = 1'b0;
               end
            end
            ST_MERGE_WR: begin
               // Inputs are held by upstream, so dm_address_o still points
               // at the word that was read in the previous cycle.
               w_wr         = 1'b1;
               w_wdata      = r_merge;
               w_state_next = ST_IDLE;
            end
            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end
   end

   // State and merge register update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_merge <= {DATA_WIDTH{1'b0}};
      end else begin
         r_state <= w_state_next;
         r_merge <= w_merge_next;
      end
   end

   assign dm_write_data_o = w_wdata;
   assign dm_mem_write_o  = w_wr;
   assign dm_mem_read_o   = w_rd;
   assign load_data_o     = w_load;
   assign stall_o         = w_stall;
   assign misaligned_o    = w_mis_out;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed plus randomized stimulus for mem_access_unit, with a small data
// memory attached to the DUT and a word-array reference model computed with
// shift/mask arithmetic. Honours MISALIGN_TRAP_EN when defined.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

   logic        clk;
   logic        reset;
   logic        mem_read_i;
   logic        mem_write_i;
   logic [1:0]  size_i;
   logic        unsigned_i;
   logic [31:0] address_i;
   logic [31:0] store_data_i;
   logic [31:0] dm_data_i;
   logic [31:0] dm_address_o;
   logic [31:0] dm_write_data_o;
   logic        dm_mem_write_o;
   logic        dm_mem_read_o;
   logic [31:0] load_data_o;
   logic        stall_o;
   logic        misaligned_o;

   int vectors;
   int miscompares;
   int cycles;

   logic [31:0] mem     [0:63];
   logic [31:0] ref_mem [0:63];
   logic        pre_we;
   logic [5:0]  pre_idx;
   logic [31:0] pre_val;

   mem_access_unit #(.DATA_WIDTH(32)) dut (
      .clk             (clk),
      .reset           (reset),
      .mem_read_i      (mem_read_i),
      .mem_write_i     (mem_write_i),
      .size_i          (size_i),
      .unsigned_i      (unsigned_i),
      .address_i       (address_i),
      .store_data_i    (store_data_i),
      .dm_data_i       (dm_data_i),
      .dm_address_o    (dm_address_o),
      .dm_write_data_o (dm_write_data_o),
      .dm_mem_write_o  (dm_mem_write_o),
      .dm_mem_read_o   (dm_mem_read_o),
      .load_data_o     (load_data_o),
      .stall_o         (stall_o),
      .misaligned_o    (misaligned_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: combinational read, write on rising edge.
   assign dm_data_i = mem[dm_address_o[7:2]];
   always @(posedge clk) begin
      cycles <= cycles + 1;
      if (pre_we) mem[pre_idx] <= pre_val;
      else if (dm_mem_write_o) mem[dm_address_o[7:2]] <= dm_write_data_o;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_mis(input logic [1:0] size, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
      if (size == 2'b00) return 1'b0;
      if (size == 2'b01) return (a % 2) != 0;
      return (a % 4) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] size,
                                            input logic [31:0] a, input logic uns);
      logic [31:0] v;
      if (size == 2'b00) begin
         v = (w >> (8 * (a % 4))) & 32'h0000_00FF;
         if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (size == 2'b01) begin
         v = (w >> (16 * ((a / 2) % 2))) & 32'h0000_FFFF;
         if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] size,
                                             input logic [31:0] a, input logic [31:0] d);
      logic [31:0] m;
      if (size == 2'b00) begin
         m = 32'h0000_00FF << (8 * (a % 4));
         return (w & ~m) | ((d & 32'h0000_00FF) << (8 * (a % 4)));
      end else if (size == 2'b01) begin
         m = 32'h0000_FFFF << (16 * ((a / 2) % 2));
         return (w & ~m) | ((d & 32'h0000_FFFF) << (16 * ((a / 2) % 2)));
      end
      return d;
   endfunction

   task automatic set_req(input logic rd, input logic wr, input logic [1:0] size,
                          input logic uns, input logic [31:0] a, input logic [31:0] d);
      mem_read_i   = rd;
      mem_write_i  = wr;
      size_i       = size;
      unsigned_i   = uns;
      address_i    = a;
      store_data_i = d;
   endtask

   task automatic preload(input logic [5:0] idx, input logic [31:0] v);
      set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      pre_we = 1'b1; pre_idx = idx; pre_val = v;
      ref_mem[idx] = v;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   task automatic do_idle();
      set_req(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'h1001_0000 + 32'($urandom_range(0, 63)), $urandom);
      #3;
      check("idle_load_data", load_data_o, 32'h0);
      check("idle_write", {31'h0, dm_mem_write_o}, 32'h0);
      check("idle_read", {31'h0, dm_mem_read_o}, 32'h0);
      check("idle_stall", {31'h0, stall_o}, 32'h0);
      @(posedge clk); #1;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [1:0] size, input logic uns,
                          output logic [31:0] obs);
      logic        mis;
      logic [31:0] exp;
      set_req(1'b1, 1'b0, size, uns, a, 32'h0);
      #3;
      mis = exp_mis(size, a);
      exp = mis ? 32'h0 : ref_load(ref_mem[a[7:2]], size, a, uns);
      check("load_data", load_data_o, exp);
      check("load_addr", dm_address_o, a & 32'hFFFF_FFFC);
      check("load_read", {31'h0, dm_mem_read_o}, 32'h1);
      check("load_write", {31'h0, dm_mem_write_o}, 32'h0);
      check("load_stall", {31'h0, stall_o}, 32'h0);
      check("load_mis", {31'h0, misaligned_o}, {31'h0, mis});
      obs = load_data_o;
      @(posedge clk); #1;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [1:0] size,
                           input logic [31:0] d, input logic both);
      logic [5:0] idx;
      logic       mis;
      idx = a[7:2];
      mis = exp_mis(size, a);
      set_req(both, 1'b1, size, 1'($urandom_range(0, 1)), a, d);
      #3;
      check("st_mis", {31'h0, misaligned_o}, {31'h0, mis});
      check("st_load_data", load_data_o, 32'h0);
      if (mis) begin
         check("st_mis_write", {31'h0, dm_mem_write_o}, 32'h0);
         check("st_mis_stall", {31'h0, stall_o}, 32'h0);
         @(posedge clk); #1;
      end else if (size >= 2'b10) begin
         check("sw_stall", {31'h0, stall_o}, 32'h0);
         check("sw_write", {31'h0, dm_mem_write_o}, 32'h1);
         check("sw_wdata", dm_write_data_o, d);
         check("sw_addr", dm_address_o, a & 32'hFFFF_FFFC);
         @(posedge clk); #1;
         ref_mem[idx] = d;
      end else begin
         check("sub_rd_stall", {31'h0, stall_o}, 32'h1);
         check("sub_rd_read", {31'h0, dm_mem_read_o}, 32'h1);
         check("sub_rd_write", {31'h0, dm_mem_write_o}, 32'h0);
         @(posedge clk); #3;
         check("sub_wr_stall", {31'h0, stall_o}, 32'h0);
         check("sub_wr_read", {31'h0, dm_mem_read_o}, 32'h0);
         check("sub_wr_write", {31'h0, dm_mem_write_o}, 32'h1);
         check("sub_wr_wdata", dm_write_data_o, ref_store(ref_mem[idx], size, a, d));
         check("sub_wr_addr", dm_address_o, a & 32'hFFFF_FFFC);
         @(posedge clk); #1;
         ref_mem[idx] = ref_store(ref_mem[idx], size, a, d);
      end
      check("st_mem", mem[idx], ref_mem[idx]);
   endtask

   initial begin
      logic [31:0] obs;
      int          t0;
      vectors = 0; miscompares = 0; cycles = 0;
      pre_we = 1'b0; pre_idx = 6'd0; pre_val = 32'h0;
      for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

      // Reset with a sub-word store held: nothing may stall or write.
      reset = 1'b0;
      set_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h1001_0001, 32'h55);
      #3;
      check("rst_stall", {31'h0, stall_o}, 32'h0);
      check("rst_write", {31'h0, dm_mem_write_o}, 32'h0);
      check("rst_mis", {31'h0, misaligned_o}, 32'h0);
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Byte/half loads with sign and zero extension.
      preload(6'd0, 32'h8899_AABB);
      do_load(32'h1001_0001, 2'b00, 1'b0, obs); check("lb_const", obs, 32'hFFFF_FFAA);
      do_load(32'h1001_0001, 2'b00, 1'b1, obs); check("lbu_const", obs, 32'h0000_00AA);
      do_load(32'h1001_0002, 2'b01, 1'b0, obs); check("lh_const", obs, 32'hFFFF_8899);
      do_load(32'h1001_0000, 2'b01, 1'b1, obs); check("lhu_const", obs, 32'h0000_AABB);

      // SB read-modify-write, then load of the merged word.
      do_store(32'h1001_0002, 2'b00, 32'h0000_00CC, 1'b0);
      check("sb_merged", mem[0], 32'h88CC_AABB);
      do_load(32'h1001_0000, 2'b10, 1'b0, obs); check("lw_after_sb", obs, 32'h88CC_AABB);

      // SW single cycle, then LW.
      do_store(32'h1001_0004, 2'b10, 32'h1234_5678, 1'b0);
      do_load(32'h1001_0004, 2'b10, 1'b0, obs); check("lw_after_sw", obs, 32'h1234_5678);

      // Reset during MERGE_WR of an SH aborts the write.
      preload(6'd2, 32'hCAFE_F00D);
      set_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h1001_000A, 32'h0000_1234);
      #3;
      check("abort_stall", {31'h0, stall_o}, 32'h1);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("abort_write", {31'h0, dm_mem_write_o}, 32'h0);
      check("abort_stall_rst", {31'h0, stall_o}, 32'h0);
      set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      #2;
      check("abort_idle_write", {31'h0, dm_mem_write_o}, 32'h0);
      check("abort_idle_stall", {31'h0, stall_o}, 32'h0);
      @(posedge clk); #1;
      check("abort_mem", mem[2], 32'hCAFE_F00D);

      // Word store with low address bits set.
      do_store(32'h1001_0002, 2'b10, 32'hA5A5_0F0F, 1'b0);
      // Simultaneous read+write handled as a store; size 11 as a word.
      do_store(32'h1001_0009, 2'b00, 32'h0000_0077, 1'b1);
      do_store(32'h1001_000C, 2'b11, 32'h0BAD_CAFE, 1'b1);

      // Two back-to-back SB: four cycles, final 0xDD0000EE.
      preload(6'd0, 32'h0);
      t0 = cycles;
      do_store(32'h0000_0000, 2'b00, 32'h0000_00EE, 1'b0);
      do_store(32'h0000_0003, 2'b00, 32'h0000_00DD, 1'b0);
      check("b2b_cycles", 32'(cycles - t0), 32'd4);
      check("b2b_word", mem[0], 32'hDD00_00EE);

      // Randomized mix against the reference model.
      for (int i = 0; i < 16; i++) preload(6'(i), $urandom);
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         logic [1:0]  sz;
         int          op;
         a  = 32'h1001_0000 + 32'($urandom_range(0, 63));
         sz = 2'($urandom_range(0, 3));
         op = $urandom_range(0, 3);
         if (op == 0)      do_idle();
         else if (op == 1) do_load(a, sz, 1'($urandom_range(0, 1)), obs);
         else              do_store(a, sz, $urandom, op == 3);
      end

      set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
